// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one N-bit ALU between two requesters.
// Handshake: grant in IDLE, one EXEC cycle, one RESP cycle with a done pulse.

module alu #(
  parameter int N = 4
) (
  input  logic [2:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  // Combinational ALU; every result wraps modulo 2^N
  always_comb begin
    y = {N{1'b0}};
    case (sel)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a + b;
      3'b011:  y = {N{1'b0}};
      3'b100:  y = a & ~b;
      3'b101:  y = a | ~b;
      3'b110:  y = a - b;
      3'b111:  y = {{(N-1){1'b0}}, (a < b)};
      default: y = {N{1'b0}};
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [2:0]   sel0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  output logic         gnt0,
  output logic         done0,
  input  logic         req1,
  input  logic [2:0]   sel1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt1,
  output logic         done1,
  output logic [N-1:0] y,
  output logic         zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic         prio_r;
  logic         owner_r;
  logic [2:0]   sel_r;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic [N-1:0] y_r;
  logic         zero_r;
  logic         done0_r;
  logic         done1_r;
  logic         gnt0_s;
  logic         gnt1_s;
  logic [N-1:0] alu_y_s;

  alu #(.N(N)) u_alu (
    .sel (sel_r),
    .a   (a_r),
    .b   (b_r),
    .y   (alu_y_s)
  );

  // Grant decode (IDLE only) and next-state logic
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          if (prio_r) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end else if (req0) begin
          gnt0_s = 1'b1;
        end else if (req1) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
        if (gnt0_s || gnt1_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, operand capture, result registers and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      prio_r  <= 1'b0;
      owner_r <= 1'b0;
      sel_r   <= 3'b000;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      y_r     <= {N{1'b0}};
      zero_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else begin
      state_r <= state_s;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      if (gnt0_s || gnt1_s) begin
        sel_r   <= gnt1_s ? sel1 : sel0;
        a_r     <= gnt1_s ? a1 : a0;
        b_r     <= gnt1_s ? b1 : b0;
        owner_r <= gnt1_s;
        prio_r  <= ~gnt1_s;
      end
      // Done is raised on the EXEC exit edge so it is high for all of RESP
      if (state_r == EXEC) begin
        y_r     <= alu_y_s;
        zero_r  <= (alu_y_s == {N{1'b0}});
        done0_r <= ~owner_r;
        done1_r <= owner_r;
      end
    end
  end

  assign gnt0  = gnt0_s;
  assign gnt1  = gnt1_s;
  assign done0 = done0_r;
  assign done1 = done1_r;
  assign y     = y_r;
  assign zero  = zero_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grants push expected results to a scoreboard,
// done pulses pop and compare them.

module tb_alu_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0;
  logic [2:0]   sel0 = 3'b000;
  logic [N-1:0] a0 = 4'd0;
  logic [N-1:0] b0 = 4'd0;
  logic         gnt0;
  logic         done0;
  logic         req1 = 1'b0;
  logic [2:0]   sel1 = 3'b000;
  logic [N-1:0] a1 = 4'd0;
  logic [N-1:0] b1 = 4'd0;
  logic         gnt1;
  logic         done1;
  logic [N-1:0] y;
  logic         zero;
  logic         busy;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .sel0(sel0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .sel1(sel1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .y(y), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [3:0] res;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   gorder[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   g0_seen = 1'b0;
  bit   g1_seen = 1'b0;

  function automatic logic [3:0] alu_m(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return 4'((a + b) % 16);
      3'd3:    return 4'd0;
      3'd4:    return a & ~b;
      3'd5:    return a | ~b;
      3'd6:    return 4'((a + 16 - b) % 16);
      3'd7:    return (a < b) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.port = port;
    e.res  = alu_m(s, a, b);
    e.z    = (e.res == 4'd0);
    e.cyc  = cyc;
    q.push_back(e);
    gorder.push_back(port);
  endtask

  task automatic monitor();
    exp_t e;
    if (gnt0 || gnt1) begin
      chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("gnt_idle", {31'd0, busy}, 32'd0);
    end
    if (gnt0) begin
      chk("gnt0_req", {31'd0, req0}, 32'd1);
      push(0, sel0, a0, b0);
      g0_seen = 1'b1;
    end
    if (gnt1) begin
      chk("gnt1_req", {31'd0, req1}, 32'd1);
      push(1, sel1, a1, b1);
      g1_seen = 1'b1;
    end
    if (done0 || done1) begin
      if (q.size() == 0) begin
        chk("done_spurious", {30'd0, done0, done1}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
        chk("done_port", done1 ? 32'd1 : 32'd0, e.port);
        chk("y", {28'd0, y}, {28'd0, e.res});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        chk("latency", cyc - e.cyc, 32'd2);
      end
    end
  endtask

  // One clock: sample at negedge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (g0_seen) req0 = 1'b0;
    if (g1_seen) req1 = 1'b0;
    g0_seen = 1'b0;
    g1_seen = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() != 0 || req0 || req1); i++) tick();
    chk("drain_done", {31'd0, (q.size() == 0 && !req0 && !req1)}, 32'd1);
  endtask

  task automatic op0(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    sel0 = s; a0 = a; b0 = b; req0 = 1'b1;
  endtask

  task automatic op1(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    sel1 = s; a1 = a; b1 = b; req1 = 1'b1;
  endtask

  initial begin
    int base;
    // Reset state
    tick(); tick();
    chk("rst_y", {28'd0, y}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {30'd0, done0, done1}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-EXEC aborts the operation
    op0(3'b010, 4'd3, 4'd4);
    tick();
    chk("exec_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_y", {28'd0, y}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done0", {31'd0, done0}, 32'd0);
    q.delete();
    gorder.delete();
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous requests: prio is 0 after reset, then alternation
    op0(3'b000, 4'd12, 4'd10);
    op1(3'b001, 4'd1, 4'd2);
    drain();
    op0(3'b000, 4'd12, 4'd10);
    op1(3'b001, 4'd1, 4'd2);
    drain();
    chk("order_n", gorder.size(), 32'd4);
    if (gorder.size() == 4) begin
      chk("order0", gorder[0], 32'd0);
      chk("order1", gorder[1], 32'd1);
      chk("order2", gorder[2], 32'd0);
      chk("order3", gorder[3], 32'd1);
    end

    // Port 1 subtract and compares
    op1(3'b110, 4'd3, 4'd5); drain();
    op1(3'b111, 4'd2, 4'd5); drain();
    op1(3'b111, 4'd5, 4'd5); drain();

    // Single add with wrap: grant in the request cycle
    base = gorder.size();
    op0(3'b010, 4'd9, 4'd9);
    tick();
    chk("add_gnt_now", gorder.size(), base + 1);
    drain();
    chk("add_y", {28'd0, y}, 32'd2);

    // Unused opcode, then result held across idle cycles
    op0(3'b011, 4'd15, 4'd15); drain();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_y", {28'd0, y}, 32'd0);
      chk("hold_zero", {31'd0, zero}, 32'd1);
      chk("hold_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    end

    // Request while busy waits for IDLE
    op0(3'b100, 4'd12, 4'd5);
    tick();
    op1(3'b101, 4'd2, 4'd12);
    #1;
    chk("busy_gnt1_exec", {31'd0, gnt1}, 32'd0);
    tick();
    chk("busy_gnt1_resp", {31'd0, gnt1}, 32'd0);
    tick();
    chk("idle_gnt1", {31'd0, gnt1}, 32'd1);
    drain();
    chk("last_y", {28'd0, y}, 32'd3);
    chk("queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one N-bit ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Accepts one operation at a time with a req/gnt handshake, registers operands, executes, registers the result, then signals completion to the owning requester with a done pulse.
- Sits between the lab's requester blocks (e.g. sequencers, test drivers) and the ALU datapath.
- The ALU is instantiated inside this block, not duplicated in logic.

Parameters:
N  4  operand/result width in bits; passed through to the internal ALU.

Ports:
clk    input   1    system clock, rising edge
rst_n  input   1    reset, asynchronous, active-low
req0   input   1    port 0 request; hold high with sel0/a0/b0 stable until gnt0
sel0   input   3    port 0 ALU operation code
a0     input   N    port 0 operand A
b0     input   N    port 0 operand B
gnt0   output  1    port 0 grant; operands captured on the edge where req0&gnt0
done0  output  1    one-cycle pulse: y/zero valid for port 0
req1   input   1    port 1 request (same rules as req0)
sel1   input   3    port 1 ALU operation code
a1     input   N    port 1 operand A
b1     input   N    port 1 operand B
gnt1   output  1    port 1 grant
done1  output  1    one-cycle pulse: y/zero valid for port 1
y      output  N    registered ALU result
zero   output  1    registered flag, 1 when y == 0
busy   output  1    1 whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, prio=0, operand regs=0, owner=0, y=0, zero=0, done0=done1=0, busy=0.
- Reset applies at any time. A reset mid-operation aborts it: no done pulse, and the result is lost.

FSM states:
- IDLE
  - gnt is combinational, only in IDLE.
  - If exactly one req is high, that port is granted.
  - If both are high, port prio is granted.
  - gnt is never asserted to a port whose req is low; at most one gnt per cycle.
  - On the edge with req&gnt: capture sel/a/b into internal regs, set owner, set prio to the other port, go to EXEC.
  - No req: stay in IDLE.
- EXEC (1 cycle)
  - The ALU sees only the registered operands.
  - On exit edge: y <= ALU result, zero <= (ALU result == 0); go to RESP.
- RESP (1 cycle)
  - done[owner]=1 (registered output, high exactly this cycle); y/zero stable.
  - Next state is IDLE.

Timing and throughput:
- Latency: grant edge T; y valid and done pulse during cycle T+2 (done asserted from edge T+2 for one cycle).
- Max throughput: one operation per 3 cycles.

Hold and reissue rules:
- y/zero hold their value until the next EXEC exit; they are not cleared by IDLE.
- A requester deasserts req after seeing gnt. A req still high in the next IDLE is treated as a new operation.
- gnt/done outputs never both high for the same port in one cycle.
- busy=1 in EXEC and RESP; requests arriving while busy wait, with no loss, as long as req is held.

ALU operation codes (N-bit, modulo 2^N):
- 000 A&B
- 001 A|B
- 010 A+B (wraps)
- 011 0
- 100 A&~B
- 101 A|~B
- 110 A-B (wraps)
- 111 (A<B) ? 1 : 0, unsigned, zero-extended

Fairness:
- prio only changes on a grant.
- Under continuous dual requests, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC (req0, sel0=010, a0=3, b0=4) -> y=0, zero=0, busy=0 immediately; no done0; after release, IDLE with prio=0.
- Single add with wrap (N=4): req0, sel0=010, a0=9, b0=9 -> gnt0 in the request cycle; done0 two cycles after grant; y=2, zero=0.
- Subtract and compare: port 1 sel1=110, a1=3, b1=5 -> y=14, done1 only. Then sel1=111, a1=2, b1=5 -> y=1; then a1=5, b1=5 -> y=0, zero=1.
- Simultaneous requests after reset:
  - req0 and req1 held high: port0 sel=000, A=12, B=10; port1 sel=001, A=1, B=2.
  - Expect gnt0 first -> y=8 with done0; then gnt1 -> y=3 with done1.
  - Reissue both: grants order 0,1 again, since prio alternates per grant.
- Unused opcode and held result: sel0=011, a0=15, b0=15 -> y=0, zero=1. Then idle 5 cycles -> y stays 0, no done pulses, gnt0/gnt1 stay low.
- Request while busy: req1 raised during port 0 EXEC -> gnt1 not asserted until IDLE; gnt1 high in the first IDLE cycle; operands captured correctly.
